// File: rtl/cl_pkg.sv
// Shared definitions for the Camera Link row capture block.
// Holds the capture state encoding, the default geometry parameters and
// the helper that locates a tap (or plane) slice inside a packed bus.
package cl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } cap_state_t;

    localparam int DEF_TAPS        = 2;
    localparam int DEF_PIXEL_WIDTH = 8;
    localparam int DEF_MAX_COLS    = 640;
    localparam int DEF_NUM_PLANES  = 5;

    // Lowest bit of slice 'idx' when slices of 'width' bits are packed LSB-first.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/cl_edge_det.sv
// Registered level plus rise/fall detection for a single control input.
// Ports:
//   CCLK  - clock
//   RST   - asynchronous, active-high reset
//   din   - raw level to watch
//   level - din delayed by one clock
//   rise  - din high now, low on the previous clock
//   fall  - din low now, high on the previous clock
// A rise is only reported once din has been seen low at least once since
// reset, so a level that is already high when reset releases (a line or
// frame in progress) is not mistaken for a fresh start.
module cl_edge_det
    import cl_pkg::*;
(
    input  logic CCLK,
    input  logic RST,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev_r;
    logic armed_r;

    // Previous-level register and the "low has been observed" arm flag.
    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            prev_r  <= din;
            armed_r <= armed_r | ~din;
        end
    end

    assign level = prev_r;
    assign rise  = din & ~prev_r & armed_r;
    assign fall  = ~din & prev_r;

endmodule

// File: rtl/cl_row_capture.sv
// Camera Link row capture: builds a dark mask and MSB bit-planes for each
// line, commits finished rows to a double-buffered output with a valid/ack
// handshake, and measures frame geometry and dropped rows.
// Ports:
//   CCLK, RST          - clock, asynchronous active-high reset
//   iVSYNC, iDE        - frame valid, line valid
//   iDATA              - NUM_TAPS pixels, tap 0 (leftmost) in the low bits
//   iTHRESHOLD         - pixels below this are dark
//   iMEM_SEL           - bank for the row being committed
//   iROW_ACK           - consumer has taken the committed row
//   oROW_VALID/IDX/LEN/OVF, oMASK, oPLANES - committed row and attributes
//   oWEA, oWEB         - bank write enables
//   oHSIZE, oVSIZE     - last line length, last frame row count
//   oFRAME_START       - one-cycle pulse on frame start
//   oDROP_CNT          - saturating count of rows lost to back-pressure
module cl_row_capture
    import cl_pkg::*;
#(
    parameter int NUM_TAPS    = DEF_TAPS,
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int MAX_COLS    = DEF_MAX_COLS,
    parameter int NUM_PLANES  = DEF_NUM_PLANES,
    parameter int ADDR_WIDTH  = 11,
    parameter int DROP_WIDTH  = 8
) (
    input  logic                             CCLK,
    input  logic                             RST,
    input  logic                             iVSYNC,
    input  logic                             iDE,
    input  logic [NUM_TAPS*PIXEL_WIDTH-1:0]  iDATA,
    input  logic [PIXEL_WIDTH-1:0]           iTHRESHOLD,
    input  logic                             iMEM_SEL,
    input  logic                             iROW_ACK,
    output logic                             oROW_VALID,
    output logic [ADDR_WIDTH-1:0]            oROW_IDX,
    output logic [ADDR_WIDTH-1:0]            oROW_LEN,
    output logic                             oROW_OVF,
    output logic                             oWEA,
    output logic                             oWEB,
    output logic [MAX_COLS-1:0]              oMASK,
    output logic [NUM_PLANES*MAX_COLS-1:0]   oPLANES,
    output logic [ADDR_WIDTH-1:0]            oHSIZE,
    output logic [ADDR_WIDTH-1:0]            oVSIZE,
    output logic                             oFRAME_START,
    output logic [DROP_WIDTH-1:0]            oDROP_CNT
);

    localparam int CW = ADDR_WIDTH + 1;

    cap_state_t state_r, state_nxt_s;

    logic de_level_s, de_rise_s, de_fall_s;
    logic vs_level_s, vs_rise_s, vs_fall_s;
    logic unused_s;

    logic start_s, cap_en_s, commit_s, xfer_s, beat_ovf_s;
    logic valid_nxt_s, bank_nxt_s, bank_r;
    logic [ADDR_WIDTH-1:0] col_r, col_base_s, col_nxt_s, row_r, len_s;
    logic [CW-1:0]         col_sum_s, col_last_s;

    logic [NUM_TAPS-1:0]                 tap_mask_s;
    logic [NUM_PLANES-1:0][NUM_TAPS-1:0] tap_plane_s;

    logic [MAX_COLS-1:0]            wmask_s;
    logic [NUM_PLANES*MAX_COLS-1:0] wplanes_s;
    logic                           wovf_r;

    cl_edge_det u_de_edge (
        .CCLK  (CCLK),
        .RST   (RST),
        .din   (iDE),
        .level (de_level_s),
        .rise  (de_rise_s),
        .fall  (de_fall_s)
    );

    cl_edge_det u_vs_edge (
        .CCLK  (CCLK),
        .RST   (RST),
        .din   (iVSYNC),
        .level (vs_level_s),
        .rise  (vs_rise_s),
        .fall  (vs_fall_s)
    );

    assign unused_s = ^{de_level_s, vs_level_s, vs_fall_s};

    // Next-state logic for the line capture FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (de_rise_s) state_nxt_s = ST_CAPTURE;
                else           state_nxt_s = ST_IDLE;
            end
            ST_CAPTURE: begin
                if (de_fall_s) state_nxt_s = ST_COMMIT;
                else           state_nxt_s = ST_CAPTURE;
            end
            ST_COMMIT: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Beat qualification, column arithmetic and commit/handshake decisions.
    always_comb begin
        start_s  = (state_r == ST_IDLE) & de_rise_s;
        cap_en_s = start_s | ((state_r == ST_CAPTURE) & iDE);
        commit_s = (state_r == ST_COMMIT);
        xfer_s   = commit_s & (~oROW_VALID | iROW_ACK);

        // The first beat of a line always lands at column 0.
        if (start_s) col_base_s = '0;
        else         col_base_s = col_r;

        col_sum_s  = {1'b0, col_base_s} + CW'(NUM_TAPS);
        col_last_s = {1'b0, col_base_s} + CW'(NUM_TAPS - 1);
        beat_ovf_s = (col_last_s >= CW'(MAX_COLS));
        if (col_sum_s[ADDR_WIDTH]) col_nxt_s = '1;
        else                       col_nxt_s = col_sum_s[ADDR_WIDTH-1:0];

        if (col_r > ADDR_WIDTH'(MAX_COLS)) len_s = ADDR_WIDTH'(MAX_COLS);
        else                               len_s = col_r;

        if (xfer_s)        valid_nxt_s = 1'b1;
        else if (iROW_ACK) valid_nxt_s = 1'b0;
        else               valid_nxt_s = oROW_VALID;

        if (xfer_s) bank_nxt_s = iMEM_SEL;
        else        bank_nxt_s = bank_r;
    end

    // Per-tap dark flag and MSB-first bit-plane bits of the current beat.
    always_comb begin
        tap_mask_s  = '0;
        tap_plane_s = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            tap_mask_s[k] = (iDATA[slice_lsb(k, PIXEL_WIDTH) +: PIXEL_WIDTH] < iTHRESHOLD);
            for (int p = 0; p < NUM_PLANES; p++) begin
                tap_plane_s[p][k] = iDATA[slice_lsb(k, PIXEL_WIDTH) + PIXEL_WIDTH - 1 - p];
            end
        end
    end

    // Working row buffer: one storage cell per column. A column is written
    // when some tap of the current beat maps onto it; otherwise it is cleared
    // at line start and held during the line.
    for (genvar c = 0; c < MAX_COLS; c++) begin : g_col
        logic [NUM_TAPS-1:0]   hit_s;
        logic [NUM_PLANES-1:0] plane_in_s;
        logic                  m_r;
        logic [NUM_PLANES-1:0] planes_r;

        for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
            if (c >= k) begin : g_hit
                assign hit_s[k] = cap_en_s & (col_base_s == ADDR_WIDTH'(c - k));
            end else begin : g_nohit
                assign hit_s[k] = 1'b0;
            end
        end

        for (genvar p = 0; p < NUM_PLANES; p++) begin : g_pl
            assign plane_in_s[p]               = |(hit_s & tap_plane_s[p]);
            assign wplanes_s[p*MAX_COLS + c]   = planes_r[p];
        end

        // Column storage update.
        always_ff @(posedge CCLK or posedge RST) begin
            if (RST) begin
                m_r      <= 1'b0;
                planes_r <= '0;
            end else if (|hit_s) begin
                m_r      <= |(hit_s & tap_mask_s);
                planes_r <= plane_in_s;
            end else if (start_s) begin
                m_r      <= 1'b0;
                planes_r <= '0;
            end
        end

        assign wmask_s[c] = m_r;
    end

    // FSM state, column counter and working overflow flag.
    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            col_r   <= '0;
            wovf_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (cap_en_s) begin
                col_r  <= col_nxt_s;
                wovf_r <= beat_ovf_s | (wovf_r & ~start_s);
            end
        end
    end

    // Frame geometry: row counter, line/frame sizes and frame-start pulse.
    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            row_r        <= '0;
            oHSIZE       <= '0;
            oVSIZE       <= '0;
            oFRAME_START <= 1'b0;
        end else begin
            oFRAME_START <= vs_rise_s;
            if (commit_s) oHSIZE <= col_r;
            // A row finishing in the frame-start cycle still belongs to the old frame.
            if (vs_rise_s) begin
                row_r <= '0;
                if (commit_s) oVSIZE <= row_r + ADDR_WIDTH'(1);
                else          oVSIZE <= row_r;
            end else if (commit_s) begin
                row_r <= row_r + ADDR_WIDTH'(1);
            end
        end
    end

    // Committed row buffer, handshake, bank enables and drop counter.
    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            oROW_VALID <= 1'b0;
            oROW_IDX   <= '0;
            oROW_LEN   <= '0;
            oROW_OVF   <= 1'b0;
            oMASK      <= '0;
            oPLANES    <= '0;
            bank_r     <= 1'b0;
            oWEA       <= 1'b0;
            oWEB       <= 1'b0;
            oDROP_CNT  <= '0;
        end else begin
            if (xfer_s) begin
                oROW_IDX <= row_r;
                oROW_LEN <= len_s;
                oROW_OVF <= wovf_r;
                oMASK    <= wmask_s;
                oPLANES  <= wplanes_s;
            end
            bank_r     <= bank_nxt_s;
            oROW_VALID <= valid_nxt_s;
            oWEA       <= valid_nxt_s & ~bank_nxt_s;
            oWEB       <= valid_nxt_s & bank_nxt_s;
            if (commit_s && !xfer_s && (oDROP_CNT != '1)) begin
                oDROP_CNT <= oDROP_CNT + DROP_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_cl_row_capture.sv
// Directed testbench for cl_row_capture (NUM_TAPS=2, 8-bit pixels, 640 columns).
module tb_cl_row_capture;

    localparam int TAPS = 2;
    localparam int PW   = 8;
    localparam int MC   = 640;
    localparam int NP   = 5;
    localparam int AW   = 11;
    localparam int DW   = 8;

    logic              CCLK = 1'b0;
    logic              RST = 1'b1;
    logic              iVSYNC = 1'b0;
    logic              iDE = 1'b0;
    logic [TAPS*PW-1:0] iDATA = '0;
    logic [PW-1:0]     iTHRESHOLD = 8'd128;
    logic              iMEM_SEL = 1'b0;
    logic              iROW_ACK = 1'b0;
    logic              oROW_VALID;
    logic [AW-1:0]     oROW_IDX;
    logic [AW-1:0]     oROW_LEN;
    logic              oROW_OVF;
    logic              oWEA;
    logic              oWEB;
    logic [MC-1:0]     oMASK;
    logic [NP*MC-1:0]  oPLANES;
    logic [AW-1:0]     oHSIZE;
    logic [AW-1:0]     oVSIZE;
    logic              oFRAME_START;
    logic [DW-1:0]     oDROP_CNT;

    int checks = 0;
    int errors = 0;
    logic [MC-1:0] all_ones;

    cl_row_capture #(
        .NUM_TAPS(TAPS), .PIXEL_WIDTH(PW), .MAX_COLS(MC),
        .NUM_PLANES(NP), .ADDR_WIDTH(AW), .DROP_WIDTH(DW)
    ) dut (
        .CCLK(CCLK), .RST(RST), .iVSYNC(iVSYNC), .iDE(iDE), .iDATA(iDATA),
        .iTHRESHOLD(iTHRESHOLD), .iMEM_SEL(iMEM_SEL), .iROW_ACK(iROW_ACK),
        .oROW_VALID(oROW_VALID), .oROW_IDX(oROW_IDX), .oROW_LEN(oROW_LEN),
        .oROW_OVF(oROW_OVF), .oWEA(oWEA), .oWEB(oWEB), .oMASK(oMASK),
        .oPLANES(oPLANES), .oHSIZE(oHSIZE), .oVSIZE(oVSIZE),
        .oFRAME_START(oFRAME_START), .oDROP_CNT(oDROP_CNT)
    );

    always #5 CCLK = ~CCLK;

    task automatic chk(input string tag, input logic [MC-1:0] obs, input logic [MC-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CCLK);
        #1;
    endtask

    task automatic beat(input logic [PW-1:0] p0, input logic [PW-1:0] p1);
        iDE   = 1'b1;
        iDATA = {p1, p0};
        tick();
    endtask

    // Drop iDE, pass the fall cycle and the COMMIT cycle.
    task automatic end_line();
        iDE   = 1'b0;
        iDATA = '0;
        tick();
        tick();
    endtask

    task automatic ack_row();
        iROW_ACK = 1'b1;
        tick();
        iROW_ACK = 1'b0;
    endtask

    initial begin
        all_ones = '1;

        // ---- reset state
        tick();
        tick();
        chk("rst_valid", MC'(oROW_VALID), MC'(1'b0));
        chk("rst_wea", MC'(oWEA), MC'(1'b0));
        chk("rst_web", MC'(oWEB), MC'(1'b0));
        chk("rst_mask", oMASK, MC'(1'b0));
        chk("rst_drop", MC'(oDROP_CNT), MC'(8'd0));
        RST = 1'b0;
        tick();

        // ---- frame start and first row
        iTHRESHOLD = 8'd128;
        iMEM_SEL   = 1'b1;
        iVSYNC     = 1'b1;
        tick();
        chk("fs_pulse", MC'(oFRAME_START), MC'(1'b1));
        chk("vsize0", MC'(oVSIZE), MC'(11'd0));
        tick();
        chk("fs_low", MC'(oFRAME_START), MC'(1'b0));
        beat(8'd10, 8'd200);
        beat(8'd10, 8'd200);
        beat(8'd255, 8'd0);
        beat(8'd127, 8'd128);
        iDE = 1'b0;
        tick();
        chk("valid_in_commit", MC'(oROW_VALID), MC'(1'b0));
        tick();
        chk("r1_valid", MC'(oROW_VALID), MC'(1'b1));
        chk("r1_idx", MC'(oROW_IDX), MC'(11'd0));
        chk("r1_len", MC'(oROW_LEN), MC'(11'd8));
        chk("r1_hsize", MC'(oHSIZE), MC'(11'd8));
        chk("r1_ovf", MC'(oROW_OVF), MC'(1'b0));
        chk("r1_mask", oMASK, MC'(8'h65));
        chk("r1_plane0", MC'(oPLANES[0*MC +: 8]), MC'(8'h9A));
        chk("r1_plane1", MC'(oPLANES[1*MC +: 8]), MC'(8'h5A));
        chk("r1_web", MC'(oWEB), MC'(1'b1));
        chk("r1_wea", MC'(oWEA), MC'(1'b0));

        // ---- back-pressure hold: bank select changes must not disturb the row
        iMEM_SEL = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", MC'(oROW_VALID), MC'(1'b1));
            chk("hold_web", MC'(oWEB), MC'(1'b1));
            chk("hold_wea", MC'(oWEA), MC'(1'b0));
            chk("hold_mask", oMASK, MC'(8'h65));
            chk("hold_idx", MC'(oROW_IDX), MC'(11'd0));
        end
        ack_row();
        chk("ack_valid", MC'(oROW_VALID), MC'(1'b0));
        chk("ack_web", MC'(oWEB), MC'(1'b0));

        // ---- drops and drop-counter saturation
        iVSYNC = 1'b0;
        tick();
        iVSYNC = 1'b1;
        tick();
        chk("vsize1", MC'(oVSIZE), MC'(11'd1));
        beat(8'd1, 8'd2);
        beat(8'd3, 8'd4);
        end_line();
        chk("a_valid", MC'(oROW_VALID), MC'(1'b1));
        chk("a_idx", MC'(oROW_IDX), MC'(11'd0));
        chk("a_drop", MC'(oDROP_CNT), MC'(8'd0));
        beat(8'd5, 8'd6);
        beat(8'd5, 8'd6);
        beat(8'd5, 8'd6);
        end_line();
        chk("b_drop", MC'(oDROP_CNT), MC'(8'd1));
        chk("b_idx", MC'(oROW_IDX), MC'(11'd0));
        chk("b_len", MC'(oROW_LEN), MC'(11'd4));
        chk("b_hsize", MC'(oHSIZE), MC'(11'd6));
        for (int i = 0; i < 259; i++) begin
            beat(8'd7, 8'd8);
            end_line();
        end
        chk("drop_sat", MC'(oDROP_CNT), MC'(8'd255));
        chk("sat_hsize", MC'(oHSIZE), MC'(11'd2));
        chk("sat_idx", MC'(oROW_IDX), MC'(11'd0));
        ack_row();

        // ---- over-long line
        iMEM_SEL = 1'b0;
        for (int i = 0; i < 330; i++) beat(8'd0, 8'd0);
        end_line();
        chk("ovf_valid", MC'(oROW_VALID), MC'(1'b1));
        chk("ovf_len", MC'(oROW_LEN), MC'(11'd640));
        chk("ovf_flag", MC'(oROW_OVF), MC'(1'b1));
        chk("ovf_hsize", MC'(oHSIZE), MC'(11'd660));
        chk("ovf_mask", oMASK, all_ones);
        chk("ovf_planes", MC'(|oPLANES), MC'(1'b0));
        chk("ovf_idx", MC'(oROW_IDX), MC'(11'd261));
        chk("ovf_wea", MC'(oWEA), MC'(1'b1));
        chk("ovf_web", MC'(oWEB), MC'(1'b0));
        chk("ovf_drop", MC'(oDROP_CNT), MC'(8'd255));
        ack_row();

        // ---- frame rollover coinciding with a commit
        iVSYNC = 1'b0;
        tick();
        iVSYNC = 1'b1;
        tick();
        chk("vsize262", MC'(oVSIZE), MC'(11'd262));
        iVSYNC = 1'b0;
        tick();
        beat(8'd255, 8'd255);
        end_line();
        chk("l0_idx", MC'(oROW_IDX), MC'(11'd0));
        chk("l0_mask_cleared", oMASK, MC'(1'b0));
        chk("l0_plane0", MC'(oPLANES[0*MC +: 8]), MC'(8'h03));
        chk("l0_ovf_cleared", MC'(oROW_OVF), MC'(1'b0));
        chk("l0_len", MC'(oROW_LEN), MC'(11'd2));
        ack_row();
        beat(8'd5, 8'd5);
        end_line();
        chk("l1_idx", MC'(oROW_IDX), MC'(11'd1));
        chk("l1_mask", oMASK, MC'(8'h03));
        ack_row();
        beat(8'd9, 8'd9);
        beat(8'd9, 8'd9);
        iDE = 1'b0;
        tick();
        iVSYNC = 1'b1;
        tick();
        chk("l2_idx", MC'(oROW_IDX), MC'(11'd2));
        chk("l2_vsize", MC'(oVSIZE), MC'(11'd3));
        chk("l2_fs", MC'(oFRAME_START), MC'(1'b1));
        chk("l2_len", MC'(oROW_LEN), MC'(11'd4));
        tick();
        chk("l2_fs_end", MC'(oFRAME_START), MC'(1'b0));
        ack_row();
        beat(8'd1, 8'd1);
        end_line();
        chk("l3_idx", MC'(oROW_IDX), MC'(11'd0));
        ack_row();

        // ---- asynchronous reset in the middle of a line
        iMEM_SEL = 1'b1;
        beat(8'd1, 8'd1);
        beat(8'd1, 8'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_hsize", MC'(oHSIZE), MC'(11'd0));
        chk("mid_rst_vsize", MC'(oVSIZE), MC'(11'd0));
        chk("mid_rst_drop", MC'(oDROP_CNT), MC'(8'd0));
        chk("mid_rst_len", MC'(oROW_LEN), MC'(11'd0));
        chk("mid_rst_mask", oMASK, MC'(1'b0));
        tick();
        RST = 1'b0;
        beat(8'd2, 8'd2);
        beat(8'd2, 8'd2);
        beat(8'd2, 8'd2);
        iDE = 1'b0;
        tick();
        tick();
        tick();
        chk("partial_valid", MC'(oROW_VALID), MC'(1'b0));
        chk("partial_hsize", MC'(oHSIZE), MC'(11'd0));
        chk("partial_fs", MC'(oFRAME_START), MC'(1'b0));
        beat(8'd50, 8'd60);
        beat(8'd70, 8'd80);
        end_line();
        chk("post_valid", MC'(oROW_VALID), MC'(1'b1));
        chk("post_idx", MC'(oROW_IDX), MC'(11'd0));
        chk("post_len", MC'(oROW_LEN), MC'(11'd4));
        chk("post_mask", oMASK, MC'(4'hF));
        chk("post_web", MC'(oWEB), MC'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
